// File: rtl/nn_pkg.sv
// Shared types and fixed-point helpers for the sequential dense layer.
// NN_SAT_EN selects saturating narrowing; otherwise results wrap to WIDTH bits.
package nn_pkg;

  localparam int NN_WIDTH = 32;
  localparam int NN_FRAC  = 16;
  localparam int NN_MAXW  = 256;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  function automatic logic signed [NN_MAXW-1:0] nn_relu(input logic signed [NN_MAXW-1:0] r);
    return (r < 0) ? '0 : r;
  endfunction

  // Result is sign-extended from bit width-1 so callers can simply truncate.
  function automatic logic signed [NN_MAXW-1:0] nn_narrow(input logic signed [NN_MAXW-1:0] r,
                                                          input int width);
`ifdef NN_SAT_EN
    logic signed [NN_MAXW-1:0] one;
    logic signed [NN_MAXW-1:0] hi;
    logic signed [NN_MAXW-1:0] lo;
    one = 1;
    hi  = (one <<< (width - 1)) - one;
    lo  = ~hi;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
`else
    return (r <<< (NN_MAXW - width)) >>> (NN_MAXW - width);
`endif
  endfunction

endpackage

// File: rtl/nn_mac.sv
// Registered signed multiply-accumulate: acc <= load ? load_val : en ? acc + a*b : acc.
// sum exposes acc + a*b so a finished neuron can be captured on the same edge it completes.
module nn_mac #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 66
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic signed [ACC_W-1:0] load_val,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] sum
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_d, acc_q;

  always_comb begin
    prod = PW'(a) * PW'(b);
    sum  = acc_q + ACC_W'(prod);
  end

  always_comb begin
    acc_d = acc_q;
    if (load)    acc_d = load_val;
    else if (en) acc_d = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/nn_seq_dense_layer.sv
// Sequential dense layer out = act(W*x + b), one product per cycle on a shared MAC.
// Narrowing saturates when NN_SAT_EN is defined, wraps otherwise.
module nn_seq_dense_layer
  import nn_pkg::*;
#(
  parameter int WIDTH = NN_WIDTH,
  parameter int FRAC  = NN_FRAC,
  parameter int NIN   = 2,
  parameter int NOUT  = 16,
  parameter int ACT   = 1,
  parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_FLAT = '0,
  parameter logic [WIDTH*NOUT-1:0]     BIAS_FLAT    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*NIN-1:0]   in_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*NOUT-1:0]  out_vec,
  output logic                   busy
);

  localparam int ACC_W = 2 * WIDTH + $clog2(NIN + 1);
  localparam int IW    = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int JW    = (NIN > 1) ? $clog2(NIN) : 1;

  state_t                  state_q, state_d;
  logic [IW-1:0]           i_q, i_d;
  logic [JW-1:0]           j_q, j_d;
  logic [WIDTH*NIN-1:0]    x_q, x_d;
  logic [WIDTH*NOUT-1:0]   out_q, out_d;

  logic signed [WIDTH-1:0]   w_sel, x_sel, b_sel, narrowed;
  logic signed [ACC_W-1:0]   sum, load_val, r_full;
  logic signed [NN_MAXW-1:0] r_act;
  logic                      load, en;
  int                        bi;

  // Bias for the neuron that starts next: b[0] on accept, b[i+1] on neuron roll-over.
  always_comb begin
    bi       = (state_q == IDLE || i_q == IW'(NOUT - 1)) ? 0 : int'(i_q) + 1;
    w_sel    = WEIGHTS_FLAT[(NOUT*NIN - (int'(i_q)*NIN + int'(j_q)))*WIDTH - 1 -: WIDTH];
    x_sel    = x_q[int'(j_q)*WIDTH +: WIDTH];
    b_sel    = BIAS_FLAT[(NOUT - 1 - bi)*WIDTH +: WIDTH];
    load_val = ACC_W'(b_sel) <<< FRAC;
    r_full   = sum >>> FRAC;
    r_act    = (ACT != 0) ? nn_relu(NN_MAXW'(r_full)) : NN_MAXW'(r_full);
    narrowed = WIDTH'(nn_narrow(r_act, WIDTH));
  end

  nn_mac #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .a        (w_sel),
    .b        (x_sel),
    .sum      (sum)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    x_d     = x_q;
    out_d   = out_q;
    load    = 1'b0;
    en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_vec;
          i_d     = '0;
          j_d     = '0;
          load    = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        en = 1'b1;
        if (j_q == JW'(NIN - 1)) begin
          out_d[int'(i_q)*WIDTH +: WIDTH] = narrowed;
          if (i_q == IW'(NOUT - 1)) begin
            state_d = DONE;
          end else begin
            i_d  = i_q + IW'(1);
            j_d  = '0;
            load = 1'b1;
          end
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      x_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      x_q     <= x_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == MAC);
  assign out_vec   = out_q;

endmodule

// File: tb/tb_nn_seq_dense_layer.sv
// Directed bench for nn_seq_dense_layer: small hand-checked layers plus a 2x16 streaming run.
module tb_nn_seq_dense_layer;

  function automatic logic [1023:0] mk_flat(input int n, input logic [31:0] seed);
    logic [1023:0] f;
    logic [31:0]   s;
    f = '0;
    s = seed;
    for (int k = 0; k < n; k++) begin
      s = s * 32'd1664525 + 32'd1013904223;
      f[k*32 +: 32] = {{12{s[27]}}, s[27:8]};
    end
    return f;
  endfunction

  localparam logic [127:0]  W1  = {32'd65536, 32'd0, 32'd0, 32'hFFFF0000};
  localparam logic [1023:0] W6  = mk_flat(32, 32'h1234_5678);
  localparam logic [1023:0] B6F = mk_flat(16, 32'h0BAD_F00D);
  localparam logic [511:0]  B6  = B6F[511:0];
`ifdef NN_SAT_EN
  localparam logic [31:0] T4_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] T4_EXP = 32'hFFFE_0000;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic iv1, ir1, ov1, or1, bz1; logic [63:0] ivec1, ovec1;
  logic iv2, ir2, ov2, or2, bz2; logic [63:0] ivec2, ovec2;
  logic iv3, ir3, ov3, or3, bz3; logic [31:0] ivec3, ovec3;
  logic iv4, ir4, ov4, or4, bz4; logic [31:0] ivec4, ovec4;
  logic iv6, ir6, ov6, or6, bz6; logic [63:0] ivec6; logic [511:0] ovec6;

  nn_seq_dense_layer #(.WIDTH(32), .FRAC(16), .NIN(2), .NOUT(2), .ACT(1),
    .WEIGHTS_FLAT(W1), .BIAS_FLAT(64'd0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_vec(ivec1),
    .out_valid(ov1), .out_ready(or1), .out_vec(ovec1), .busy(bz1));

  nn_seq_dense_layer #(.WIDTH(32), .FRAC(16), .NIN(2), .NOUT(2), .ACT(0),
    .WEIGHTS_FLAT(W1), .BIAS_FLAT(64'd0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_vec(ivec2),
    .out_valid(ov2), .out_ready(or2), .out_vec(ovec2), .busy(bz2));

  nn_seq_dense_layer #(.WIDTH(32), .FRAC(16), .NIN(1), .NOUT(1), .ACT(0),
    .WEIGHTS_FLAT(32'd1), .BIAS_FLAT(32'd0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_vec(ivec3),
    .out_valid(ov3), .out_ready(or3), .out_vec(ovec3), .busy(bz3));

  nn_seq_dense_layer #(.WIDTH(32), .FRAC(16), .NIN(1), .NOUT(1), .ACT(0),
    .WEIGHTS_FLAT(32'd131072), .BIAS_FLAT(32'd0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_vec(ivec4),
    .out_valid(ov4), .out_ready(or4), .out_vec(ovec4), .busy(bz4));

  nn_seq_dense_layer #(.WIDTH(32), .FRAC(16), .NIN(2), .NOUT(16), .ACT(1),
    .WEIGHTS_FLAT(W6), .BIAS_FLAT(B6)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6), .in_vec(ivec6),
    .out_valid(ov6), .out_ready(or6), .out_vec(ovec6), .busy(bz6));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent Q16.16 reference for the 2-in/16-out ReLU layer.
  function automatic logic [511:0] model6(input logic [63:0] xv);
    logic signed [127:0] acc, r;
    logic signed [31:0]  w, x, bb;
    logic [511:0]        o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      bb  = B6[(15-i)*32 +: 32];
      acc = 128'(bb) <<< 16;
      for (int j = 0; j < 2; j++) begin
        w   = W6[(32-(i*2+j))*32-1 -: 32];
        x   = xv[j*32 +: 32];
        acc = acc + 128'(w) * 128'(x);
      end
      r = acc >>> 16;
      if (r < 0) r = '0;
`ifdef NN_SAT_EN
      if (r > 128'sh7FFF_FFFF) r = 128'sh7FFF_FFFF;
`endif
      o[i*32 +: 32] = r[31:0];
    end
    return o;
  endfunction

  logic [511:0] expq[$];
  logic [511:0] snap;
  logic [63:0]  xnew;
  logic         hold_ok, stable, spacing_ok, afire, ofire;
  int           n, sent, recv, cyc, last_acc;

  initial begin
    rst_n = 1'b0;
    {iv1, or1, iv2, or2, iv3, or3, iv4, or4, iv6, or6} = '0;
    ivec1 = '0; ivec2 = '0; ivec3 = '0; ivec4 = '0; ivec6 = '0;
    tick(); tick();
    chk("rst_in_ready", ir1, 1'b1);
    chk("rst_out_valid", ov1, 1'b0);
    chk("rst_busy", bz1, 1'b0);
    chk("rst_out_vec", ovec6, 512'd0);
    rst_n = 1'b1;
    tick();

    // T1: ReLU layer, latency and in_ready held low until handoff
    ivec1 = {32'd65536, 32'd131072};
    iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    chk("t1_busy", bz1, 1'b1);
    n = 0; hold_ok = 1'b1;
    while (!ov1 && n < 20) begin
      tick(); n++;
      if (ir1) hold_ok = 1'b0;
    end
    chk("t1_latency", 32'(n), 32'd4);
    chk("t1_in_ready_low", hold_ok, 1'b1);
    chk("t1_out_vec", ovec1, {32'd0, 32'd131072});
    or1 = 1'b1;
    tick();
    or1 = 1'b0;
    chk("t1_handoff_valid", ov1, 1'b0);
    chk("t1_handoff_ready", ir1, 1'b1);

    // T2: identity layer, output held while downstream stalls
    ivec2 = {32'd65536, 32'd131072};
    iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    n = 0;
    while (!ov2 && n < 20) begin tick(); n++; end
    chk("t2_latency", 32'(n), 32'd4);
    snap = 512'(ovec2); stable = 1'b1;
    repeat (10) begin
      tick();
      if (!ov2 || 512'(ovec2) !== snap) stable = 1'b0;
    end
    chk("t2_stall_stable", stable, 1'b1);
    chk("t2_out_vec", ovec2, {32'hFFFF0000, 32'd131072});
    or2 = 1'b1;
    tick();
    or2 = 1'b0;
    chk("t2_handoff_valid", ov2, 1'b0);

    // T3: single neuron, floor of a tiny negative product
    ivec3 = 32'hFFFF_FFFF;
    iv3 = 1'b1;
    tick();
    iv3 = 1'b0;
    chk("t3_busy", bz3, 1'b1);
    tick();
    chk("t3_valid_1edge", ov3, 1'b1);
    chk("t3_out_vec", ovec3, 32'hFFFF_FFFF);
    or3 = 1'b1; tick(); or3 = 1'b0;

    // T4: narrowing overflow
    ivec4 = 32'h7FFF_0000;
    iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    tick();
    chk("t4_valid", ov4, 1'b1);
    chk("t4_out_vec", ovec4, T4_EXP);
    or4 = 1'b1; tick(); or4 = 1'b0;

    // T5: async reset in the middle of a vector, after neuron 0 was written
    ivec1 = {32'd65536, 32'd131072};
    iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    tick(); tick();
    chk("t5_busy_before", bz1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", ov1, 1'b0);
    chk("t5_rst_vec", ovec1, 64'd0);
    chk("t5_rst_ready", ir1, 1'b1);
    chk("t5_rst_busy", bz1, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    ivec1 = {32'hFFFE_0000, 32'd196608};
    iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    n = 0;
    while (!ov1 && n < 20) begin tick(); n++; end
    chk("t5_latency", 32'(n), 32'd4);
    chk("t5_out_vec", ovec1, {32'd131072, 32'd196608});
    or1 = 1'b1; tick(); or1 = 1'b0;

    // T6: 50 back-to-back vectors with random downstream stalls
    sent = 0; recv = 0; cyc = 0; last_acc = -1000; spacing_ok = 1'b1;
    ivec6 = {$urandom, $urandom};
    expq.push_back(model6(ivec6));
    iv6 = 1'b1;
    while (recv < 50 && cyc < 8000) begin
      or6   = ($urandom_range(0, 3) != 0);
      afire = iv6 && ir6;
      ofire = ov6 && or6;
      if (ofire) begin
        chk("t6_not_extra", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) chk("t6_vec", ovec6, expq.pop_front());
        recv++;
      end
      if (afire) begin
        if (cyc - last_acc < 34) spacing_ok = 1'b0;
        last_acc = cyc;
      end
      tick();
      cyc++;
      if (afire) begin
        sent++;
        if (sent < 50) begin
          xnew = {$urandom, $urandom};
          if (sent % 2 == 1)
            xnew = {32'($signed(xnew[63:32]) >>> 12), 32'($signed(xnew[31:0]) >>> 12)};
          ivec6 = xnew;
          expq.push_back(model6(ivec6));
        end else begin
          iv6 = 1'b0;
        end
      end
    end
    or6 = 1'b0;
    chk("t6_recv_count", 32'(recv), 32'd50);
    chk("t6_sent_count", 32'(sent), 32'd50);
    chk("t6_queue_empty", 32'(expq.size()), 32'd0);
    chk("t6_no_early_accept", spacing_ok, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
